q_update_pipe: RTL and testbench

Q_UPDATE_PIPE -- requirements
Module: q_update_pipe

---
 rtl/q_update_pipe.sv | 156 +++++++++++++++
 tb/tb_q_update_pipe.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/q_update_pipe.sv
// q_update_pipe
// Three-stage fixed-point Q-learning update:
//   q_new = q + ALPHA * (r + GAMMA * maxq - q)
// Data words are two's complement Q(DATA_LENGTH-K_QFACTOR).K_QFACTOR.
// Every add, subtract and multiply saturates. out_sat reports that at
// least one clamp altered a value belonging to this result.
//
// Ports
//   clk           : sole clock, rising edge
//   rst_n         : synchronous active-low reset
//   in_valid      : input sample valid
//   in_ready      : block accepts an input this cycle
//   in_reward     : reward r
//   in_q_cur      : current Q(s,a)
//   in_q_next_max : max over a' of Q(s',a')
//   in_addr       : Q-table address tag, carried alongside the sample
//   out_valid     : result valid
//   out_ready     : downstream accepts the result
//   out_q_new     : updated Q value
//   out_addr      : tag accompanying out_q_new
//   out_sat       : a saturation occurred for this result
//
// Flow control: one global advance enable for the whole pipe. Bubbles
// move with the data and are not squeezed out while stalled.
module q_update_pipe #(
  parameter int DATA_LENGTH = 32,
  parameter int K_QFACTOR   = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter logic [DATA_LENGTH-1:0] ALPHA = 32'h0000_8000,
  parameter logic [DATA_LENGTH-1:0] GAMMA = 32'h0000_E666
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_LENGTH-1:0] in_reward,
  input  logic [DATA_LENGTH-1:0] in_q_cur,
  input  logic [DATA_LENGTH-1:0] in_q_next_max,
  input  logic [ADDR_WIDTH-1:0]  in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LENGTH-1:0] out_q_new,
  output logic [ADDR_WIDTH-1:0]  out_addr,
  output logic                   out_sat
);

  localparam int W  = DATA_LENGTH;
  localparam int PW = 2 * DATA_LENGTH;

  // Sign-extend a data word to double width so sums, differences and
  // shifted products can be range-checked before clamping.
  function automatic logic signed [PW-1:0] sext(input logic [W-1:0] a);
    sext = {{W{a[W-1]}}, a};
  endfunction

  // Clamp a double-width value into the data range.
  // Returns {clamped_flag, value}.
  function automatic logic [W:0] satWide(input logic signed [PW-1:0] x);
    logic signed [PW-1:0] hi;
    logic signed [PW-1:0] lo;
    hi = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    lo = {{(W+1){1'b1}}, {(W-1){1'b0}}};
    if (x > hi) begin
      satWide = {1'b1, hi[W-1:0]};
    end else if (x < lo) begin
      satWide = {1'b1, lo[W-1:0]};
    end else begin
      satWide = {1'b0, x[W-1:0]};
    end
  endfunction

  // Fixed-point multiply: full-width product, arithmetic shift (rounds
  // toward minus infinity), then clamp. Returns {clamped_flag, value}.
  function automatic logic [W:0] fxMul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [PW-1:0] p;
    p = sext(a) * sext(b);
    fxMul = satWide(p >>> K_QFACTOR);
  endfunction

  logic                  w_en;
  logic [W:0]            w_gm;
  logic [W:0]            w_t1;
  logic [W:0]            w_d;
  logic [W:0]            w_am;
  logic [W:0]            w_qn;

  logic                  r_s1Valid;
  logic [W-1:0]          r_s1T1;
  logic [W-1:0]          r_s1Q;
  logic [ADDR_WIDTH-1:0] r_s1Addr;
  logic                  r_s1Sat;

  logic                  r_s2Valid;
  logic [W-1:0]          r_s2D;
  logic [W-1:0]          r_s2Q;
  logic [ADDR_WIDTH-1:0] r_s2Addr;
  logic                  r_s2Sat;

  logic                  r_outValid;
  logic [W-1:0]          r_outQ;
  logic [ADDR_WIDTH-1:0] r_outAddr;
  logic                  r_outSat;

  // The pipe only moves when the output slot is empty or being drained,
  // so accepting an input and consuming a result can share a cycle.
  assign w_en     = !r_outValid || out_ready;
  assign in_ready = w_en;

  assign w_gm = fxMul(GAMMA, in_q_next_max);
  assign w_t1 = satWide(sext(in_reward) + sext(w_gm[W-1:0]));
  assign w_d  = satWide(sext(r_s1T1) - sext(r_s1Q));
  assign w_am = fxMul(ALPHA, r_s2D);
  assign w_qn = satWide(sext(r_s2Q) + sext(w_am[W-1:0]));

  // Stage registers. Data is loaded whenever the pipe advances, even for
  // bubbles; only the valid bits say whether a slot holds a real sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1Valid  <= 1'b0;
      r_s1T1     <= '0;
      r_s1Q      <= '0;
      r_s1Addr   <= '0;
      r_s1Sat    <= 1'b0;
      r_s2Valid  <= 1'b0;
      r_s2D      <= '0;
      r_s2Q      <= '0;
      r_s2Addr   <= '0;
      r_s2Sat    <= 1'b0;
      r_outValid <= 1'b0;
      r_outQ     <= '0;
      r_outAddr  <= '0;
      r_outSat   <= 1'b0;
    end else if (w_en) begin
      r_s1Valid  <= in_valid;
      r_s1T1     <= w_t1[W-1:0];
      r_s1Q      <= in_q_cur;
      r_s1Addr   <= in_addr;
      r_s1Sat    <= w_gm[W] | w_t1[W];
      r_s2Valid  <= r_s1Valid;
      r_s2D      <= w_d[W-1:0];
      r_s2Q      <= r_s1Q;
      r_s2Addr   <= r_s1Addr;
      r_s2Sat    <= r_s1Sat | w_d[W];
      r_outValid <= r_s2Valid;
      r_outQ     <= w_qn[W-1:0];
      r_outAddr  <= r_s2Addr;
      r_outSat   <= r_s2Sat | w_am[W] | w_qn[W];
    end
  end

  assign out_valid = r_outValid;
  assign out_q_new = r_outQ;
  assign out_addr  = r_outAddr;
  assign out_sat   = r_outSat;

endmodule

// File: tb/tb_q_update_pipe.sv
// Testbench for q_update_pipe (default parameters: 32-bit words, 16
// fraction bits, 8-bit tags). A scoreboard holds the expected result for
// every accepted sample, computed with 64-bit integer arithmetic, and a
// negedge process compares it against every valid output cycle. Directed
// sections pin reset values, latency, stall behaviour and streaming.
module tb_q_update_pipe;

  localparam longint MAXL    = 64'sh0000_0000_7FFF_FFFF;
  localparam longint MINL    = -64'sh0000_0000_8000_0000;
  localparam longint ONE     = 64'sh0000_0000_0001_0000;
  localparam longint ALPHA_L = 64'sh0000_0000_0000_8000;
  localparam longint GAMMA_L = 64'sh0000_0000_0000_E666;

  typedef struct packed {
    logic [7:0]  addr;
    logic        sat;
    logic [31:0] q;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_reward;
  logic [31:0] in_q_cur;
  logic [31:0] in_q_next_max;
  logic [7:0]  in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_q_new;
  logic [7:0]  out_addr;
  logic        out_sat;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   accCount = 0;
  bit   streamOn = 1'b0;
  int   streamBeats = 0;
  int   firstBeat = 0;
  int   lastBeat = 0;
  exp_t expQ[$];

  q_update_pipe #(
    .DATA_LENGTH(32),
    .K_QFACTOR(16),
    .ADDR_WIDTH(8),
    .ALPHA(32'h0000_8000),
    .GAMMA(32'h0000_E666)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_reward(in_reward),
    .in_q_cur(in_q_cur),
    .in_q_next_max(in_q_next_max),
    .in_addr(in_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_q_new(out_q_new),
    .out_addr(out_addr),
    .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  // Reference arithmetic: clamp to the 32-bit signed range, noting any clamp.
  function automatic longint clampTo(input longint x, inout bit s);
    longint res;
    res = x;
    if (x > MAXL) begin
      s = 1'b1;
      res = MAXL;
    end else if (x < MINL) begin
      s = 1'b1;
      res = MINL;
    end
    return res;
  endfunction

  // Fixed-point product scaled back by 2^16, rounded toward minus infinity.
  function automatic longint fxProd(input longint a, input longint b);
    longint p;
    longint qt;
    p  = a * b;
    qt = p / ONE;
    if ((p % ONE) != 0 && p < 0) qt = qt - 1;
    return qt;
  endfunction

  // Expected {sat, q_new} for one sample.
  function automatic logic [32:0] refUpdate(input logic [31:0] r, input logic [31:0] mq,
                                            input logic [31:0] q);
    bit     s;
    longint rl;
    longint ml;
    longint ql;
    longint t1;
    longint d;
    longint n;
    longint tmp;
    s   = 1'b0;
    rl  = longint'($signed(r));
    ml  = longint'($signed(mq));
    ql  = longint'($signed(q));
    tmp = clampTo(fxProd(GAMMA_L, ml), s);
    t1  = clampTo(rl + tmp, s);
    d   = clampTo(t1 - ql, s);
    tmp = clampTo(fxProd(ALPHA_L, d), s);
    n   = clampTo(ql + tmp, s);
    return {s, n[31:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] r, input logic [31:0] mq,
                               input logic [31:0] q, input logic [7:0] a);
    in_valid      = v;
    in_reward     = r;
    in_q_next_max = mq;
    in_q_cur      = q;
    in_addr       = a;
  endtask

  task automatic nextDrive();
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((expQ.size() != 0 || out_valid) && n < budget) begin
      nextDrive();
      n++;
    end
    if (expQ.size() != 0 || out_valid) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: pending=%0d out_valid=%0b after %0d cycles",
               expQ.size(), out_valid, n);
    end
  endtask

  // Single sample through an otherwise idle pipe: the result must appear
  // in the third cycle after the handshake cycle, not earlier.
  task automatic runDirected(input logic [31:0] r, input logic [31:0] mq, input logic [31:0] q,
                             input logic [7:0] a, input logic [31:0] expQv, input logic expS);
    applyStimulus(1'b1, r, mq, q, a);
    @(negedge clk);
    checkOutput("dir_in_ready", in_ready, 1);
    nextDrive();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
    @(negedge clk);
    checkOutput("dir_lat1_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("dir_lat2_valid", out_valid, 0);
    @(negedge clk);
    checkOutput("dir_lat3_valid", out_valid, 1);
    checkOutput("dir_q_new", out_q_new, expQv);
    checkOutput("dir_sat", out_sat, expS);
    checkOutput("dir_addr", out_addr, a);
    nextDrive();
    waitDrain(20);
  endtask

  // Scoreboard and compare process. Handshakes are judged at the negedge
  // preceding the edge that completes them.
  always @(negedge clk) begin
    logic [32:0] m;
    exp_t        e;
    cyc++;
    if (!rst_n) begin
      expQ.delete();
    end else begin
      checkOutput("in_ready_rule", in_ready, !out_valid || out_ready);
      if (out_valid) begin
        if (expQ.size() == 0) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result: addr=%0h q=%0h with nothing outstanding",
                   out_addr, out_q_new);
        end else begin
          e = expQ[0];
          checkOutput("result_addr", out_addr, e.addr);
          checkOutput("result_q", out_q_new, e.q);
          checkOutput("result_sat", out_sat, e.sat);
          if (out_ready) begin
            void'(expQ.pop_front());
            if (streamOn) begin
              if (streamBeats == 0) firstBeat = cyc;
              lastBeat = cyc;
              streamBeats++;
            end
          end
        end
      end
      if (in_valid && in_ready) begin
        m = refUpdate(in_reward, in_q_next_max, in_q_cur);
        e.addr = in_addr;
        e.sat  = m[32];
        e.q    = m[31:0];
        expQ.push_back(e);
        accCount++;
      end
    end
  end

  initial begin
    int acc0;
    logic [31:0] r;
    logic [31:0] mq;
    logic [31:0] q;
    int ri;

    rst_n     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 8'h0);

    // Hand-computed values pin the reference model.
    checkOutput("model_pin_basic", refUpdate(32'h0001_0000, 32'h0002_0000, 32'h0), {1'b0, 32'h0001_6666});
    checkOutput("model_pin_neg", refUpdate(32'hFFFF_0000, 32'h0, 32'h0), {1'b0, 32'hFFFF_8000});
    checkOutput("model_pin_sat", refUpdate(32'h7FFF_0000, 32'h7FFF_0000, 32'h0), {1'b1, 32'h3FFF_FFFF});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_valid", out_valid, 0);
    checkOutput("reset_q", out_q_new, 0);
    checkOutput("reset_addr", out_addr, 0);
    checkOutput("reset_sat", out_sat, 0);
    nextDrive();
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    nextDrive();

    // Directed single samples
    runDirected(32'h0001_0000, 32'h0002_0000, 32'h0000_0000, 8'hA1, 32'h0001_6666, 1'b0);
    runDirected(32'hFFFF_0000, 32'h0000_0000, 32'h0000_0000, 8'hA2, 32'hFFFF_8000, 1'b0);
    runDirected(32'h7FFF_0000, 32'h7FFF_0000, 32'h0000_0000, 8'hA3, 32'h3FFF_FFFF, 1'b1);

    // Stall: with out_ready low three samples fill the pipe, the fourth waits.
    $display("[TB] stall section");
    out_ready = 1'b0;
    acc0 = accCount;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h0001_0000 * (i + 1), 32'h0000_8000, 32'h0000_4000, 8'h30 + 8'(i));
      @(negedge clk);
      if (i < 3) checkOutput("stall_in_ready_hi", in_ready, 1);
      else       checkOutput("stall_in_ready_lo", in_ready, 0);
      nextDrive();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("stall_hold_ready", in_ready, 0);
      checkOutput("stall_hold_valid", out_valid, 1);
      checkOutput("stall_hold_addr", out_addr, 8'h30);
      nextDrive();
    end
    checkOutput("stall_accepted3", accCount - acc0, 3);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("stall_release_ready", in_ready, 1);
    nextDrive();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
    waitDrain(20);
    checkOutput("stall_accepted4", accCount - acc0, 4);

    // Reset with two samples in flight: nothing may emerge afterwards.
    $display("[TB] mid-flight reset section");
    applyStimulus(1'b1, 32'h0002_0000, 32'h0001_0000, 32'h0, 8'h51);
    nextDrive();
    applyStimulus(1'b1, 32'h0003_0000, 32'h0001_0000, 32'h0, 8'h52);
    nextDrive();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", out_valid, 0);
    checkOutput("midrst_q", out_q_new, 0);
    checkOutput("midrst_addr", out_addr, 0);
    checkOutput("midrst_sat", out_sat, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    nextDrive();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("midrst_no_stale", out_valid, 0);
      nextDrive();
    end

    // Continuous stream: one result per cycle, tags in order.
    $display("[TB] stream section");
    streamOn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      ri = (i - 5) * 65536;
      r  = ri;
      mq = i * 32768;
      ri = (3 - i) * 16384;
      q  = ri;
      if (i == 7) begin
        r  = 32'h8000_0000;
        mq = 32'h8000_0000;
        q  = 32'h0001_0000;
      end
      if (i == 8) begin
        r  = 32'h7FFF_0000;
        mq = 32'h7FFF_0000;
        q  = 32'h8000_0000;
      end
      applyStimulus(1'b1, r, mq, q, 8'(i));
      @(negedge clk);
      checkOutput("stream_in_ready", in_ready, 1);
      nextDrive();
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0, 8'h0);
    waitDrain(20);
    streamOn = 1'b0;
    checkOutput("stream_beats", streamBeats, 10);
    checkOutput("stream_back_to_back", lastBeat - firstBeat, 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
